noc_inject_sequencer: RTL and testbench

//  Automatic packet-injection controller for the 16-router NoC test harness.

---
 rtl/noc_inject_sequencer.sv | 177 +++++++++++++++++
 tb/tb_noc_inject_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_sequencer.sv
// rtl/noc_inject_sequencer.sv - automatic packet-injection sequencer for the NoC test harness
module noc_inject_sequencer #(
  parameter int N_ROUTERS   = 16,
  parameter int DATA_W      = 10,
  parameter int RID_W       = 5,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            mode,
  input  logic [RID_W-1:0]                cfg_router,
  input  logic [DATA_W-1:0]               cfg_data,
  input  logic [N_ROUTERS-1:0]            router_ack,
  output logic [N_ROUTERS*(DATA_W+1)-1:0] out_bus,
  output logic                            busy,
  output logic                            done,
  output logic [RID_W-1:0]                cur_router,
  output logic [7:0]                      pkt_count,
  output logic                            timeout_err,
  output logic                            range_err
);

  localparam int PKT_W = DATA_W + 1;
  localparam int BUS_W = N_ROUTERS * PKT_W;
  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [RID_W-1:0] LAST_RID = RID_W'(N_ROUTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INJECT = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [RID_W-1:0]   cur_router_q, cur_router_d;
  logic [7:0]         pkt_count_q, pkt_count_d;
  logic [7:0]         timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;
  logic               range_err_q, range_err_d;
  logic [BUS_W-1:0]   out_bus_q, out_bus_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_sel;

  // Builds a bus image with only the slot at idx carrying {flag, payload}.
  function automatic logic [BUS_W-1:0] slot_pkt(input logic [RID_W-1:0] idx,
                                                input logic [DATA_W-1:0] d);
    logic [BUS_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_ROUTERS; i++) begin
      if (idx == RID_W'(i)) v[i*PKT_W +: PKT_W] = {1'b1, d};
    end
    return v;
  endfunction

  // Pick the ack bit of the currently targeted router; all other acks are ignored.
  always_comb begin
    ack_sel = 1'b0;
    for (int i = 0; i < N_ROUTERS; i++) begin
      if (cur_router_q == RID_W'(i)) ack_sel = router_ack[i];
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    data_d        = data_q;
    cur_router_d  = cur_router_q;
    pkt_count_d   = pkt_count_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    range_err_d   = range_err_q;
    out_bus_d     = out_bus_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d        = mode;
          data_d        = cfg_data;
          pkt_count_d   = '0;
          timeout_err_d = 1'b0;
          range_err_d   = 1'b0;
          timer_d       = '0;
          if (mode && (32'(cfg_router) >= N_ROUTERS)) begin
            range_err_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            cur_router_d = mode ? cfg_router : '0;
            out_bus_d    = slot_pkt(cur_router_d, cfg_data);
            state_d      = S_INJECT;
          end
        end
      end
      S_INJECT: begin
        if (ack_sel) begin
          pkt_count_d = (pkt_count_q == 8'hFF) ? pkt_count_q : pkt_count_q + 8'd1;
          out_bus_d   = '0;
          timer_d     = '0;
          state_d     = S_GAP;
        end else if (timer_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          out_bus_d     = '0;
          timer_d       = '0;
          state_d       = S_GAP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (!mode_q && (cur_router_q < LAST_RID)) begin
            cur_router_d = cur_router_q + RID_W'(1);
            data_d       = data_q + DATA_W'(1);
            out_bus_d    = slot_pkt(cur_router_d, data_d);
            state_d      = S_INJECT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_INJECT) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any run and clears the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      data_q        <= '0;
      cur_router_q  <= '0;
      pkt_count_q   <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      range_err_q   <= 1'b0;
      out_bus_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      cur_router_q  <= cur_router_d;
      pkt_count_q   <= pkt_count_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
      range_err_q   <= range_err_d;
      out_bus_q     <= out_bus_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign out_bus     = out_bus_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cur_router  = cur_router_q;
  assign pkt_count   = pkt_count_q;
  assign timeout_err = timeout_err_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_noc_inject_sequencer.sv
// tb/tb_noc_inject_sequencer.sv - directed self-checking bench for noc_inject_sequencer
module tb_noc_inject_sequencer;

  localparam int NR = 16;
  localparam int DW = 10;
  localparam int RW = 5;
  localparam int PW = DW + 1;
  localparam int BW = NR * PW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [RW-1:0] cfg_router;
  logic [DW-1:0] cfg_data;
  logic [NR-1:0] router_ack;
  logic [BW-1:0] out_bus;
  logic          busy;
  logic          done;
  logic [RW-1:0] cur_router;
  logic [7:0]    pkt_count;
  logic          timeout_err;
  logic          range_err;

  int n_tests;
  int n_fail;

  noc_inject_sequencer #(
    .N_ROUTERS  (NR),
    .DATA_W     (DW),
    .RID_W      (RW),
    .GAP_CYCLES (4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .cfg_router (cfg_router),
    .cfg_data   (cfg_data),
    .router_ack (router_ack),
    .out_bus    (out_bus),
    .busy       (busy),
    .done       (done),
    .cur_router (cur_router),
    .pkt_count  (pkt_count),
    .timeout_err(timeout_err),
    .range_err  (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] pkt(input int r, input logic [DW-1:0] d);
    logic [BW-1:0] v;
    v = '0;
    v[r*PW +: PW] = {1'b1, d};
    return v;
  endfunction

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    chk(tag, BW'(done), BW'(1));
  endtask

  initial begin
    logic [DW-1:0] d;
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    cfg_router = '0;
    cfg_data = '0;
    router_ack = '0;
    tick();
    tick();
    chk("rst_bus", out_bus, '0);
    chk("rst_flags", BW'({busy, done, timeout_err, range_err}), '0);
    chk("rst_cnt", BW'({cur_router, pkt_count}), '0);
    rst_n = 1'b1;
    tick();

    // 1: single shot to router 5, ack after 3 cycles
    start = 1'b1; mode = 1'b1; cfg_router = 5'd5; cfg_data = 10'h1A3;
    tick();
    start = 1'b0;
    chk("t1_pkt_c1", out_bus, pkt(5, 10'h1A3));
    chk("t1_slice", BW'(out_bus[65:55]), BW'(11'h5A3));
    chk("t1_busy", BW'(busy), BW'(1));
    chk("t1_cur", BW'(cur_router), BW'(5));
    tick();
    chk("t1_pkt_c2", out_bus, pkt(5, 10'h1A3));
    tick();
    chk("t1_pkt_c3", out_bus, pkt(5, 10'h1A3));
    router_ack = 16'h0020;
    tick();
    router_ack = '0;
    chk("t1_clr", out_bus, '0);
    chk("t1_cnt", BW'(pkt_count), BW'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_gap", BW'({busy, done, (|out_bus)}), BW'(3'b100));
    end
    tick();
    chk("t1_done", BW'({busy, done}), BW'(2'b01));
    tick();
    chk("t1_done_end", BW'(done), BW'(0));
    chk("t1_cnt_hold", BW'(pkt_count), BW'(1));

    // 5: wrong-slot ack ignored
    start = 1'b1; mode = 1'b1; cfg_router = 5'd3; cfg_data = 10'h055;
    tick();
    start = 1'b0;
    router_ack = 16'h0010;
    tick();
    chk("t5_ign1", out_bus, pkt(3, 10'h055));
    tick();
    chk("t5_ign2", out_bus, pkt(3, 10'h055));
    router_ack = 16'h0008;
    tick();
    router_ack = '0;
    chk("t5_clr", out_bus, '0);
    chk("t5_cnt", BW'(pkt_count), BW'(1));
    wait_done("t5_done");
    tick();

    // 3: timeout after 8 cycles without ack
    start = 1'b1; mode = 1'b1; cfg_router = 5'd2; cfg_data = 10'h111;
    tick();
    start = 1'b0;
    chk("t3_pkt_c1", out_bus, pkt(2, 10'h111));
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_hold", out_bus, pkt(2, 10'h111));
    end
    tick();
    chk("t3_clr", out_bus, '0);
    chk("t3_terr", BW'(timeout_err), BW'(1));
    wait_done("t3_done");
    chk("t3_cnt", BW'(pkt_count), BW'(0));
    tick();

    // 4: range error, also clears the sticky timeout
    start = 1'b1; mode = 1'b1; cfg_router = 5'd17; cfg_data = 10'h2AA;
    tick();
    start = 1'b0;
    chk("t4_flags", BW'({done, busy, range_err, timeout_err}), BW'(4'b1010));
    chk("t4_bus", out_bus, '0);
    tick();
    chk("t4_done_end", BW'({done, range_err}), BW'(2'b01));

    // 2: sweep with acks tied high, payload wraps
    start = 1'b1; mode = 1'b0; cfg_data = 10'h3FE; router_ack = '1;
    tick();
    start = 1'b0;
    for (int r = 0; r < NR; r++) begin
      d = DW'(10'h3FE + r);
      chk($sformatf("t2_pkt%0d", r), out_bus, pkt(r, d));
      chk($sformatf("t2_cur%0d", r), BW'(cur_router), BW'(r));
      tick();
      chk($sformatf("t2_gap%0d", r), out_bus, '0);
      tick(); tick(); tick();
      chk($sformatf("t2_nodone%0d", r), BW'(done), BW'(0));
      tick();
    end
    chk("t2_done", BW'({done, busy}), BW'(2'b10));
    chk("t2_cnt", BW'(pkt_count), BW'(16));
    chk("t2_errs", BW'({range_err, timeout_err}), '0);
    tick();
    chk("t2_done_end", BW'(done), BW'(0));
    router_ack = '0;

    // 6: reset mid-sweep at router 7
    start = 1'b1; mode = 1'b0; cfg_data = 10'h020;
    tick();
    start = 1'b0;
    router_ack = '1;
    begin
      int k;
      k = 0;
      while (!(cur_router === 5'd7 && (|out_bus)) && k < 200) begin
        tick();
        k++;
      end
    end
    chk("t6_at7", out_bus, pkt(7, 10'h027));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bus", out_bus, '0);
    chk("t6_rst_flags", BW'({busy, done, cur_router, pkt_count}), '0);
    tick();
    chk("t6_rst_nodone", BW'(done), BW'(0));
    router_ack = '0;
    rst_n = 1'b1;
    tick();
    start = 1'b1; mode = 1'b0; cfg_data = 10'h020;
    tick();
    start = 1'b0;
    chk("t6_fresh", out_bus, pkt(0, 10'h020));
    start = 1'b1; mode = 1'b1; cfg_router = 5'd9; cfg_data = 10'h3AA;
    tick();
    start = 1'b0;
    chk("t6_ign_bus", out_bus, pkt(0, 10'h020));
    chk("t6_ign_cur", BW'(cur_router), BW'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
